pe_tile_param: RTL and testbench



---
 rtl/pe_tile_pkg.sv | 36 +++
 rtl/config_reg_bank.sv | 75 +++++++
 rtl/pe_tile_param.sv | 131 +++++++++++++
 tb/tb_pe_tile_param.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pe_tile_pkg.sv
// Shared definitions for the parametrised PE tile: sides, opcodes,
// config register indices and switch-box select codes.
package pe_tile_pkg;

    typedef enum logic [1:0] {
        SIDE_N = 2'd0,
        SIDE_E = 2'd1,
        SIDE_S = 2'd2,
        SIDE_W = 2'd3
    } side_e;

    localparam logic [2:0] OP_AND    = 3'd0;
    localparam logic [2:0] OP_OR     = 3'd1;
    localparam logic [2:0] OP_XOR    = 3'd2;
    localparam logic [2:0] OP_ADD    = 3'd3;
    localparam logic [2:0] OP_SUB    = 3'd4;
    localparam logic [2:0] OP_PASS_A = 3'd5;
    localparam logic [2:0] OP_PASS_B = 3'd6;
    localparam logic [2:0] OP_NOT_A  = 3'd7;

    localparam logic [15:0] REG_PE_OP   = 16'd0;
    localparam logic [15:0] REG_CB0     = 16'd1;
    localparam logic [15:0] REG_CB1     = 16'd2;
    localparam logic [15:0] REG_SB_BASE = 16'd3;

    // Select code k routes from side (s+k+1)%4; SB_PE takes the PE result.
    localparam logic [1:0] SB_NEXT1 = 2'd0;
    localparam logic [1:0] SB_NEXT2 = 2'd1;
    localparam logic [1:0] SB_NEXT3 = 2'd2;
    localparam logic [1:0] SB_PE    = 2'd3;

    function automatic int unsigned side_rot(input int unsigned s, input int unsigned k);
        return (s + k) % 4;
    endfunction

endpackage

// File: rtl/config_reg_bank.sv
// Config address decoder and the seven tile configuration registers,
// with a read-old readback register.
module config_reg_bank
    import pe_tile_pkg::*;
#(
    parameter int CB_W = 4,
    parameter int SB_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       tile_id,
    input  logic [31:0]       config_addr,
    input  logic [31:0]       config_data,
    input  logic              config_valid,
    output logic [31:0]       config_rd_data,
    output logic [2:0]        pe_op,
    output logic [CB_W-1:0]   cb0_sel,
    output logic [CB_W-1:0]   cb1_sel,
    output logic [4*SB_W-1:0] sb_sel
);

    logic            hit;
    logic [15:0]     idx;
    logic [31:0]     rd_val;
    logic [SB_W-1:0] sb_q [4];
    logic            unused_data;

    assign hit         = (config_addr[31:16] == tile_id);
    assign idx         = config_addr[15:0];
    assign unused_data = ^config_data;

    always_comb begin
        rd_val = '0;
        case (idx)
            REG_PE_OP:           rd_val[2:0]      = pe_op;
            REG_CB0:             rd_val[CB_W-1:0] = cb0_sel;
            REG_CB1:             rd_val[CB_W-1:0] = cb1_sel;
            REG_SB_BASE:         rd_val[SB_W-1:0] = sb_q[0];
            REG_SB_BASE + 16'd1: rd_val[SB_W-1:0] = sb_q[1];
            REG_SB_BASE + 16'd2: rd_val[SB_W-1:0] = sb_q[2];
            REG_SB_BASE + 16'd3: rd_val[SB_W-1:0] = sb_q[3];
            default:             rd_val           = '0;
        endcase
    end

    // Readback samples the pre-write value, so a same-cycle write reads old.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pe_op          <= '0;
            cb0_sel        <= '0;
            cb1_sel        <= '0;
            config_rd_data <= '0;
            for (int s = 0; s < 4; s++) sb_q[s] <= '0;
        end else begin
            if (hit) config_rd_data <= rd_val;
            if (config_valid && hit) begin
                case (idx)
                    REG_PE_OP:           pe_op   <= config_data[2:0];
                    REG_CB0:             cb0_sel <= config_data[CB_W-1:0];
                    REG_CB1:             cb1_sel <= config_data[CB_W-1:0];
                    REG_SB_BASE:         sb_q[0] <= config_data[SB_W-1:0];
                    REG_SB_BASE + 16'd1: sb_q[1] <= config_data[SB_W-1:0];
                    REG_SB_BASE + 16'd2: sb_q[2] <= config_data[SB_W-1:0];
                    REG_SB_BASE + 16'd3: sb_q[3] <= config_data[SB_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    for (genvar s = 0; s < 4; s++) begin : g_sb_flat
        assign sb_sel[s*SB_W +: SB_W] = sb_q[s];
    end

endmodule

// File: rtl/pe_tile_param.sv
// Parametrised routing tile: two connect boxes, a registered PE and a
// per-side switch box with optional output registering.
module pe_tile_param
    import pe_tile_pkg::*;
#(
    parameter int       TRACK_WIDTH = 1,
    parameter int       NUM_TRACKS  = 4,
    parameter bit [3:0] SIDE_MASK   = 4'b1111,
    parameter bit       SB_REG      = 1'b0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [15:0]                         tile_id,
    input  logic [31:0]                         config_addr,
    input  logic [31:0]                         config_data,
    input  logic                                config_valid,
    output logic [31:0]                         config_rd_data,
    input  logic [4*NUM_TRACKS*TRACK_WIDTH-1:0] in_wires,
    output logic [4*NUM_TRACKS*TRACK_WIDTH-1:0] out_wires,
    output logic [TRACK_WIDTH-1:0]              pe_out
);

    localparam int TW    = TRACK_WIDTH;
    localparam int NT    = NUM_TRACKS;
    localparam int BUS_W = 4 * NT * TW;
    // One extra bit so that the "operand is zero" range is reachable.
    localparam int CB_W  = $clog2(2 * NT) + 1;
    localparam int SB_W  = 2 * NT;

    logic [2:0]        pe_op;
    logic [CB_W-1:0]   cb0_sel;
    logic [CB_W-1:0]   cb1_sel;
    logic [4*SB_W-1:0] sb_sel;
    logic [TW-1:0]     a_p0;
    logic [TW-1:0]     b_p0;
    logic [BUS_W-1:0]  sb_next;
    logic              unused_sel;

    config_reg_bank #(
        .CB_W (CB_W),
        .SB_W (SB_W)
    ) u_cfg (
        .clk            (clk),
        .reset          (reset),
        .tile_id        (tile_id),
        .config_addr    (config_addr),
        .config_data    (config_data),
        .config_valid   (config_valid),
        .config_rd_data (config_rd_data),
        .pe_op          (pe_op),
        .cb0_sel        (cb0_sel),
        .cb1_sel        (cb1_sel),
        .sb_sel         (sb_sel)
    );

    // Masked sides never look at their select bits.
    assign unused_sel = ^sb_sel;

    function automatic logic [TW-1:0] cb_pick(input logic [BUS_W-1:0] iw,
                                              input logic [BUS_W-1:0] ow,
                                              input int unsigned      side,
                                              input logic [CB_W-1:0]  sel);
        int unsigned k;
        k = 32'(sel);
        if (k < NT)
            return TW'(iw >> ((side * NT + k) * TW));
        else if (k < 2 * NT)
            return TW'(ow >> ((side * NT + k - NT) * TW));
        else
            return '0;
    endfunction

    function automatic logic [TW-1:0] pe_alu(input logic [2:0]    op,
                                             input logic [TW-1:0] a,
                                             input logic [TW-1:0] b);
        logic [TW-1:0] r;
        case (op)
            OP_AND:    r = a & b;
            OP_OR:     r = a | b;
            OP_XOR:    r = a ^ b;
            OP_ADD:    r = a + b;
            OP_SUB:    r = a - b;
            OP_PASS_A: r = a;
            OP_PASS_B: r = b;
            default:   r = ~a;
        endcase
        return r;
    endfunction

    // Stage p0: connect-box operand selection.
    assign a_p0 = cb_pick(in_wires, out_wires, 0, cb0_sel);
    assign b_p0 = cb_pick(in_wires, out_wires, 1, cb1_sel);

    // Stage p1: registered PE result.
    always_ff @(posedge clk) begin
        if (!reset) pe_out <= '0;
        else        pe_out <= pe_alu(pe_op, a_p0, b_p0);
    end

    for (genvar s = 0; s < 4; s++) begin : g_side
        for (genvar t = 0; t < NT; t++) begin : g_trk
            localparam int O  = (s * NT + t) * TW;
            localparam int I1 = (int'(side_rot(s, 1)) * NT + t) * TW;
            localparam int I2 = (int'(side_rot(s, 2)) * NT + t) * TW;
            localparam int I3 = (int'(side_rot(s, 3)) * NT + t) * TW;
            if (SIDE_MASK[s]) begin : g_on
                logic [1:0] code;
                assign code = sb_sel[s*SB_W + 2*t +: 2];
                assign sb_next[O +: TW] = (code == SB_PE)    ? pe_out :
                                          (code == SB_NEXT3) ? in_wires[I3 +: TW] :
                                          (code == SB_NEXT2) ? in_wires[I2 +: TW] :
                                                               in_wires[I1 +: TW];
            end else begin : g_off
                assign sb_next[O +: TW] = '0;
            end
        end
    end

    if (SB_REG) begin : g_sb_reg
        // Stage p1: switch-box output register.
        logic [BUS_W-1:0] sb_out_p1;
        always_ff @(posedge clk) begin
            if (!reset) sb_out_p1 <= '0;
            else        sb_out_p1 <= sb_next;
        end
        assign out_wires = sb_out_p1;
    end else begin : g_sb_comb
        assign out_wires = sb_next;
    end

endmodule

// File: tb/tb_pe_tile_param.sv
// Directed bench for pe_tile_param: a fully enabled registered tile and a
// half-masked combinational tile share one config bus and input bus.
module tb_pe_tile_param;

    localparam logic [15:0] TID = 16'h0005;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  config_addr;
    logic [31:0]  config_data;
    logic         config_valid;
    logic [127:0] in_wires;
    logic [127:0] out_a, out_m;
    logic [7:0]   pe_a, pe_m;
    logic [31:0]  rd_a, rd_m;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pe_tile_param #(
        .TRACK_WIDTH (8),
        .NUM_TRACKS  (4),
        .SIDE_MASK   (4'b1111),
        .SB_REG      (1'b1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .tile_id        (TID),
        .config_addr    (config_addr),
        .config_data    (config_data),
        .config_valid   (config_valid),
        .config_rd_data (rd_a),
        .in_wires       (in_wires),
        .out_wires      (out_a),
        .pe_out         (pe_a)
    );

    pe_tile_param #(
        .TRACK_WIDTH (8),
        .NUM_TRACKS  (4),
        .SIDE_MASK   (4'b0011),
        .SB_REG      (1'b0)
    ) dut_m (
        .clk            (clk),
        .reset          (reset),
        .tile_id        (TID),
        .config_addr    (config_addr),
        .config_data    (config_data),
        .config_valid   (config_valid),
        .config_rd_data (rd_m),
        .in_wires       (in_wires),
        .out_wires      (out_m),
        .pe_out         (pe_m)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] trk(input logic [127:0] bus, input int s, input int t);
        return (bus >> ((s * 4 + t) * 8)) & 128'hFF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [15:0] idx, input logic [31:0] data);
        config_addr  = {TID, idx};
        config_data  = data;
        config_valid = 1'b1;
        tick();
        config_valid = 1'b0;
    endtask

    task automatic read_reg(input logic [15:0] idx);
        config_addr = {TID, idx};
        tick();
    endtask

    initial begin
        reset        = 1'b0;
        config_addr  = 32'h0;
        config_data  = 32'h0;
        config_valid = 1'b0;
        in_wires     = '1;
        tick();
        tick();
        chk("reset_out",    out_a, 128'h0);
        chk("reset_pe",     {120'h0, pe_a}, 128'h0);
        chk("reset_rd",     {96'h0, rd_a}, 128'h0);
        chk("reset_mask_m", out_m, {64'h0, {64{1'b1}}});

        // Side 0 track 0 = F0, side 1 track 1 = 20.
        reset    = 1'b1;
        in_wires = 128'h0;
        in_wires[7:0]   = 8'hF0;
        in_wires[47:40] = 8'h20;
        write_reg(16'd0, 32'd3);
        write_reg(16'd1, 32'd0);
        write_reg(16'd2, 32'd1);
        tick();
        chk("pe_add_wrap", {120'h0, pe_a}, 128'h10);
        read_reg(16'd0);
        chk("rd_pe_op",   {96'h0, rd_a}, 128'd3);
        chk("rd_pe_op_m", {96'h0, rd_m}, 128'd3);
        read_reg(16'd2);
        chk("rd_cb1", {96'h0, rd_a}, 128'd1);
        chk("sb_default_route",   trk(out_a, 0, 1), 128'h20);
        chk("sb_default_route_m", trk(out_m, 0, 1), 128'h20);

        write_reg(16'd5, 32'h3);
        tick();
        chk("sb_pe_route", trk(out_a, 2, 0), 128'h10);
        write_reg(16'd0, 32'd2);
        tick();
        chk("pe_xor", {120'h0, pe_a}, 128'hD0);
        chk("sb_lag", trk(out_a, 2, 0), 128'h10);
        tick();
        chk("sb_follow", trk(out_a, 2, 0), 128'hD0);

        write_reg(16'd0, 32'd5);
        chk("rd_read_old", {96'h0, rd_a}, 128'd2);
        read_reg(16'd0);
        chk("rd_read_new", {96'h0, rd_a}, 128'd5);
        chk("pe_pass_a",   {120'h0, pe_a}, 128'hF0);

        config_addr  = {16'h0006, 16'd0};
        config_data  = 32'd7;
        config_valid = 1'b1;
        tick();
        config_valid = 1'b0;
        chk("rd_hold_miss", {96'h0, rd_a}, 128'd5);
        read_reg(16'd0);
        chk("miss_no_write", {96'h0, rd_a}, 128'd5);
        write_reg(16'd9, 32'hFFFF_FFFF);
        read_reg(16'd9);
        chk("rd_unmapped", {96'h0, rd_a}, 128'd0);
        read_reg(16'd5);
        chk("idx9_no_write", {96'h0, rd_a}, 128'd3);

        write_reg(16'd3, 32'hFF);
        write_reg(16'd6, 32'h55);
        tick();
        chk("mask_sides_m", out_m, {96'h0, 32'hF0F0_F0F0});
        chk("pe_m",         {120'h0, pe_m}, 128'hF0);
        chk("sb_code1",     trk(out_a, 3, 1), 128'h20);

        write_reg(16'd1, 32'd8);
        tick();
        chk("cb_out_of_range", {120'h0, pe_a}, 128'h0);

        reset = 1'b0;
        tick();
        chk("midrst_pe",    {120'h0, pe_a}, 128'h0);
        chk("midrst_out",   out_a, 128'h0);
        chk("midrst_rd",    {96'h0, rd_a}, 128'h0);
        chk("midrst_out_m", out_m, 128'h2000);
        reset = 1'b1;
        read_reg(16'd0);
        chk("midrst_pe_op", {96'h0, rd_a}, 128'h0);
        read_reg(16'd5);
        chk("midrst_sb2",   {96'h0, rd_a}, 128'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
